// File: rtl/param_stack_alu.sv
// Stack-based ALU with a push-down operand stack.
// MUL runs on an iterative shift-add multiplier, one bit per cycle.
module param_stack_alu #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               opcode,
  input  logic [WIDTH-1:0]         input_data,
  output logic [WIDTH-1:0]         output_data,
  output logic                     out_valid,
  output logic                     overflow,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      ptr, ia, ib;
  logic [WIDTH-1:0]   opa, opb, sum, diff;
  logic               accept, two, legal;
  logic [WIDTH-1:0]   res;
  logic               ovf;
  logic [CW-1:0]      cnt_n;

  logic [2*WIDTH-1:0] acc, mcand, term, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [SW-1:0]      step;
  logic               last, mul_done, mul_ovf;

  assign ptr      = count[AW-1:0];
  assign ia       = ptr - AW'(1);
  assign ib       = ptr - AW'(2);
  assign opa      = mem[ia];
  assign opb      = mem[ib];
  assign sum      = opb + opa;
  assign diff     = opb - opa;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign two      = (count >= CW'(2));
  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;

  assign last     = (step == SW'(WIDTH-1));
  assign mul_done = (state == S_MUL) & last;
  // Sign bit of the multiplier carries negative weight.
  assign term     = mplier[0] ? (last ? -mcand : mcand) : '0;
  assign acc_nx   = acc + term;
  assign mul_ovf  = !((&acc_nx[2*WIDTH-1:WIDTH-1]) ||
                      !(|acc_nx[2*WIDTH-1:WIDTH-1]));

  always_comb begin
    legal = 1'b0;
    res   = output_data;
    ovf   = 1'b0;
    cnt_n = count;
    unique case (opcode)
      OP_NOP: ;
      OP_PUSH: begin
        legal = !full;
        res   = input_data;
        cnt_n = count + CW'(1);
      end
      OP_POP: begin
        legal = !empty;
        res   = opa;
        cnt_n = count - CW'(1);
      end
      OP_ADD: begin
        legal = two;
        res   = sum;
        ovf   = (opb[WIDTH-1] == opa[WIDTH-1]) &&
                (sum[WIDTH-1] != opb[WIDTH-1]);
        cnt_n = count - CW'(1);
      end
      OP_SUB: begin
        legal = two;
        res   = diff;
        ovf   = (opb[WIDTH-1] != opa[WIDTH-1]) &&
                (diff[WIDTH-1] != opb[WIDTH-1]);
        cnt_n = count - CW'(1);
      end
      OP_DUP: begin
        legal = !empty && !full;
        res   = opa;
        cnt_n = count + CW'(1);
      end
      OP_SWAP: begin
        legal = two;
        res   = opb;
      end
      OP_MUL: legal = two;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept && opcode == OP_MUL && legal)
          state_n = S_MUL;
      S_MUL:
        if (last) state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      output_data <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      step        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && opcode != OP_NOP) begin
        if (!legal) begin
          error     <= 1'b1;
          overflow  <= 1'b0;
          out_valid <= 1'b1;
        end else if (opcode != OP_MUL) begin
          error       <= 1'b0;
          overflow    <= ovf;
          output_data <= res;
          count       <= cnt_n;
          out_valid   <= 1'b1;
        end else begin
          acc    <= '0;
          mcand  <= {{WIDTH{opb[WIDTH-1]}}, opb};
          mplier <= opa;
          step   <= '0;
        end
      end
      if (state == S_MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        step   <= step + SW'(1);
        if (last) begin
          output_data <= acc_nx[WIDTH-1:0];
          overflow    <= mul_ovf;
          error       <= 1'b0;
          count       <= count - CW'(1);
          out_valid   <= 1'b1;
        end
      end
    end
  end

  // Storage is never reset; entries above count are unreachable.
  always_ff @(posedge clock) begin
    if (accept && legal) begin
      unique case (opcode)
        OP_PUSH: mem[ptr] <= input_data;
        OP_ADD:  mem[ib]  <= sum;
        OP_SUB:  mem[ib]  <= diff;
        OP_DUP:  mem[ptr] <= opa;
        OP_SWAP: begin
          mem[ia] <= opb;
          mem[ib] <= opa;
        end
        default: ;
      endcase
    end
    if (mul_done) mem[ib] <= acc_nx[WIDTH-1:0];
  end

endmodule

// File: tb/tb_param_stack_alu.sv
// Directed self-checking bench for param_stack_alu.
// WIDTH=32, DEPTH=16.
module tb_param_stack_alu;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] DUP  = 3'b010;
  localparam logic [2:0] SWAP = 3'b011;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  opcode = 3'b000;
  logic [31:0] input_data = '0;
  logic [31:0] output_data;
  logic        out_valid, overflow, error;
  logic [4:0]  count;
  logic        empty, full;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  param_stack_alu #(.WIDTH(32), .DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .input_data(input_data),
    .output_data(output_data), .out_valid(out_valid),
    .overflow(overflow), .error(error),
    .count(count), .empty(empty), .full(full)
  );

  task automatic cmd(input logic [2:0] op, input logic [31:0] d);
    @(negedge clock);
    in_valid   = 1'b1;
    opcode     = op;
    input_data = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    opcode   = NOP;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_mul(output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({in_ready, empty, full, out_valid, overflow, error} !== 6'b110000)
      $display("FAIL reset_flags got %b exp 110000",
               {in_ready, empty, full, out_valid, overflow, error});
    else passed++;
    total++;
    if (count !== 5'd0 || output_data !== 32'd0)
      $display("FAIL reset_vals got cnt=%0d out=%0d exp 0 0",
               count, output_data);
    else passed++;
    do_reset();
  endtask

  task automatic test_add();
    logic [31:0] prev;
    cmd(PUSH, 32'd100000);
    cmd(PUSH, 32'd12345);
    cmd(ADD, 32'd0);
    total++;
    if (output_data !== 32'd112345 || overflow !== 1'b0 || error !== 1'b0)
      $display("FAIL add got out=%0d ov=%b er=%b exp 112345 0 0",
               output_data, overflow, error);
    else passed++;
    total++;
    if (count !== 5'd1 || out_valid !== 1'b1)
      $display("FAIL add_cnt got cnt=%0d ov=%b exp 1 1", count, out_valid);
    else passed++;
    prev = output_data;
    cmd(NOP, 32'd55);
    total++;
    if (out_valid !== 1'b0 || count !== 5'd1 || output_data !== 32'd112345)
      $display("FAIL nop got vld=%b cnt=%0d out=%0d exp 0 1 112345",
               out_valid, count, output_data);
    else passed++;
    cmd(POP, 32'd0);
  endtask

  task automatic test_mul();
    int n;
    cmd(PUSH, 32'd1000000);
    cmd(PUSH, 32'd3000000);
    cmd(MUL, 32'd0);
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL mul_busy got in_ready=%b exp 0", in_ready);
    else passed++;
    in_valid   = 1'b1;
    opcode     = PUSH;
    input_data = 32'd77;
    wait_mul(n);
    in_valid = 1'b0;
    opcode   = NOP;
    total++;
    if (n !== 32)
      $display("FAIL mul_cycles got %0d exp 32", n);
    else passed++;
    total++;
    if (output_data !== 32'd2112827392 || overflow !== 1'b1 ||
        out_valid !== 1'b1)
      $display("FAIL mul got out=%0d ov=%b vld=%b exp 2112827392 1 1",
               output_data, overflow, out_valid);
    else passed++;
    @(posedge clock);
    #1;
    total++;
    if (count !== 5'd1 || out_valid !== 1'b0)
      $display("FAIL mul_cnt got cnt=%0d vld=%b exp 1 0", count, out_valid);
    else passed++;
    cmd(POP, 32'd0);
    cmd(PUSH, -32'sd3);
    cmd(PUSH, 32'd7);
    cmd(MUL, 32'd0);
    wait_mul(n);
    total++;
    if (output_data !== 32'hFFFF_FFEB || overflow !== 1'b0 || n !== 32)
      $display("FAIL mul_neg got out=%h ov=%b n=%0d exp ffffffeb 0 32",
               output_data, overflow, n);
    else passed++;
    cmd(POP, 32'd0);
  endtask

  task automatic test_add_ovf();
    cmd(PUSH, 32'd2147483647);
    cmd(PUSH, 32'd1);
    cmd(ADD, 32'd0);
    total++;
    if (output_data !== 32'h8000_0000 || overflow !== 1'b1)
      $display("FAIL add_ovf got out=%h ov=%b exp 80000000 1",
               output_data, overflow);
    else passed++;
    cmd(POP, 32'd0);
    cmd(PUSH, 32'd5);
    cmd(PUSH, 32'd7);
    cmd(SUB, 32'd0);
    total++;
    if (output_data !== 32'hFFFF_FFFE || overflow !== 1'b0 || count !== 5'd1)
      $display("FAIL sub got out=%h ov=%b cnt=%0d exp fffffffe 0 1",
               output_data, overflow, count);
    else passed++;
    cmd(POP, 32'd0);
  endtask

  task automatic test_bounds();
    do_reset();
    cmd(POP, 32'd0);
    total++;
    if (error !== 1'b1 || output_data !== 32'd0 || count !== 5'd0 ||
        out_valid !== 1'b1)
      $display("FAIL pop_empty got er=%b out=%0d cnt=%0d vld=%b exp 1 0 0 1",
               error, output_data, count, out_valid);
    else passed++;
    for (int i = 1; i <= 16; i++) cmd(PUSH, 32'(i));
    total++;
    if (error !== 1'b0 || full !== 1'b1 || count !== 5'd16)
      $display("FAIL push16 got er=%b full=%b cnt=%0d exp 0 1 16",
               error, full, count);
    else passed++;
    cmd(PUSH, 32'd17);
    total++;
    if (error !== 1'b1 || full !== 1'b1 || count !== 5'd16 ||
        output_data !== 32'd16 || overflow !== 1'b0)
      $display("FAIL push17 got er=%b full=%b cnt=%0d out=%0d exp 1 1 16 16",
               error, full, count, output_data);
    else passed++;
    cmd(POP, 32'd0);
    total++;
    if (output_data !== 32'd16 || count !== 5'd15 || error !== 1'b0)
      $display("FAIL pop_full got out=%0d cnt=%0d er=%b exp 16 15 0",
               output_data, count, error);
    else passed++;
    for (int i = 0; i < 14; i++) cmd(POP, 32'd0);
    cmd(MUL, 32'd0);
    total++;
    if (in_ready !== 1'b1 || error !== 1'b1 || count !== 5'd1)
      $display("FAIL mul_illegal got rdy=%b er=%b cnt=%0d exp 1 1 1",
               in_ready, error, count);
    else passed++;
    cmd(POP, 32'd0);
    total++;
    if (empty !== 1'b1 || output_data !== 32'd1)
      $display("FAIL drain got empty=%b out=%0d exp 1 1", empty, output_data);
    else passed++;
  endtask

  task automatic test_swap();
    cmd(PUSH, 32'd3);
    cmd(PUSH, 32'd9);
    cmd(SWAP, 32'd0);
    total++;
    if (output_data !== 32'd3 || count !== 5'd2)
      $display("FAIL swap got out=%0d cnt=%0d exp 3 2", output_data, count);
    else passed++;
    cmd(POP, 32'd0);
    total++;
    if (output_data !== 32'd3)
      $display("FAIL swap_pop1 got %0d exp 3", output_data);
    else passed++;
    cmd(POP, 32'd0);
    total++;
    if (output_data !== 32'd9)
      $display("FAIL swap_pop2 got %0d exp 9", output_data);
    else passed++;
    cmd(DUP, 32'd0);
    total++;
    if (error !== 1'b1 || count !== 5'd0 || output_data !== 32'd9)
      $display("FAIL dup_empty got er=%b cnt=%0d out=%0d exp 1 0 9",
               error, count, output_data);
    else passed++;
  endtask

  task automatic test_reset_mul();
    cmd(PUSH, 32'd6);
    cmd(PUSH, 32'd7);
    cmd(MUL, 32'd0);
    for (int i = 0; i < 10; i++) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({in_ready, empty, full, out_valid, overflow, error} !== 6'b110000 ||
        count !== 5'd0 || output_data !== 32'd0)
      $display("FAIL reset_mul got flags=%b cnt=%0d out=%0d exp 110000 0 0",
               {in_ready, empty, full, out_valid, overflow, error},
               count, output_data);
    else passed++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cmd(PUSH, 32'd4);
    total++;
    if (count !== 5'd1 || output_data !== 32'd4 || out_valid !== 1'b1)
      $display("FAIL post_reset got cnt=%0d out=%0d vld=%b exp 1 4 1",
               count, output_data, out_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_add_ovf();
    test_bounds();
    test_swap();
    test_reset_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
